// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared types for the memory-access stage: FSM state encoding,
//            MEM pipeline register layout and the memop decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    // Width of the bus wait counter; holds TIMEOUT values up to 255.
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Everything the stage hands to write-back, registered as one word.
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] read_data;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_to_reg;
        logic        bus_err;
    } mem_out_t;

    // An instruction touches data memory if it loads or stores.
    function automatic logic is_memop(input logic mem_to_reg, input logic mem_write);
        return mem_to_reg | mem_write;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module   : dff
// Brief    : Core flop primitive: WIDTH-bit register, asynchronous active-low
//            reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Plain register, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= d;
    end

endmodule
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts cycles an outstanding bus access has waited; raises
//            expire when the count reaches TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic expire
);

    logic [TIMER_W-1:0] count;

    // Clear wins over start, start (load 1) wins over increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    count <= '0;
        else if (clear)  count <= '0;
        else if (start)  count <= TIMER_W'(1);
        else if (enable) count <= count + TIMER_W'(1);
    end

    assign expire = (count == TIMER_W'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : MIPS memory-access stage. Issues loads/stores on a req/ack data
//            bus, stalls the core while an access is outstanding, drains a
//            flushed access, and flags misaligned or timed-out accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Result_MEM,
    output logic [31:0] ReadData_MEM,
    output logic [4:0]  WriteReg_MEM,
    output logic        RegWrite_MEM,
    output logic        MemToReg_MEM,
    output logic        Stall_MEM,
    output logic        BusErr_MEM
);

    state_t      state;
    logic [31:0] h_addr;
    logic [31:0] h_wdata;
    logic [4:0]  h_wreg;
    logic        h_we;
    logic        h_regwrite;
    logic        h_memtoreg;

    logic        memop;
    logic        aligned;
    logic        busy;
    logic        issue;
    logic        expire;
    logic        stall;
    logic        tmr_clear;
    logic        tmr_start;
    logic        tmr_enable;
    mem_out_t    mem_d;
    mem_out_t    mem_q;

    assign memop   = is_memop(MemToReg_EX, MemWrite_EX);
    assign aligned = (Result_EX[1:0] == 2'b00);
    assign busy    = (state != ST_IDLE);
    // A new access starts only from IDLE; flush suppresses it.
    assign issue   = (state == ST_IDLE) && memop && aligned && !flush;

    // Once busy, the bus is driven from the holding registers so it stays
    // stable regardless of what EX presents or whether flush arrives.
    assign dmem_req   = reset_n && (issue || busy);
    assign dmem_we    = busy ? h_we    : (issue && MemWrite_EX);
    assign dmem_addr  = busy ? h_addr  : (issue ? Result_EX : 32'h0);
    assign dmem_wdata = busy ? h_wdata : (issue ? WrDat_EX  : 32'h0);

    assign tmr_start  = issue && !dmem_ack;
    assign tmr_clear  = busy && (dmem_ack || expire);
    assign tmr_enable = busy && !dmem_ack && !expire;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmr_clear),
        .start   (tmr_start),
        .enable  (tmr_enable),
        .expire  (expire)
    );

    // Stall while the access is outstanding; a drain stalls through its
    // final cycle so whatever sits in EX is not skipped.
    always_comb begin
        case (state)
            ST_IDLE:  stall = issue && !dmem_ack;
            ST_WAIT:  stall = !dmem_ack && !expire;
            ST_DRAIN: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    assign Stall_MEM = reset_n && stall;

    // Next value of the MEM registers: bubble by default, real results on
    // completion, flush clears everything.
    always_comb begin
        mem_d            = mem_q;
        mem_d.reg_write  = 1'b0;
        mem_d.mem_to_reg = 1'b0;
        mem_d.bus_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!memop) begin
                    mem_d.result    = Result_EX;
                    mem_d.write_reg = WriteReg_EX;
                    mem_d.reg_write = RegWrite_EX;
                end else if (!aligned) begin
                    mem_d.bus_err = 1'b1;
                end else if (dmem_ack) begin
                    mem_d.result     = Result_EX;
                    mem_d.write_reg  = WriteReg_EX;
                    mem_d.reg_write  = RegWrite_EX && !MemWrite_EX;
                    mem_d.mem_to_reg = MemToReg_EX && !MemWrite_EX;
                    if (!MemWrite_EX) mem_d.read_data = dmem_rdata;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    mem_d.result     = h_addr;
                    mem_d.write_reg  = h_wreg;
                    mem_d.reg_write  = h_regwrite && !h_we;
                    mem_d.mem_to_reg = h_memtoreg && !h_we;
                    if (!h_we) mem_d.read_data = dmem_rdata;
                end else if (expire) begin
                    mem_d.bus_err = 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (flush) mem_d = '0;
    end

    dff #(
        .WIDTH ($bits(mem_out_t))
    ) u_mem_regs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (mem_d),
        .q       (mem_q)
    );

    assign Result_MEM   = mem_q.result;
    assign ReadData_MEM = mem_q.read_data;
    assign WriteReg_MEM = mem_q.write_reg;
    assign RegWrite_MEM = mem_q.reg_write;
    assign MemToReg_MEM = mem_q.mem_to_reg;
    assign BusErr_MEM   = mem_q.bus_err;

    // Access FSM and holding registers for the in-flight bus transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            h_addr     <= 32'h0;
            h_wdata    <= 32'h0;
            h_wreg     <= 5'h0;
            h_we       <= 1'b0;
            h_regwrite <= 1'b0;
            h_memtoreg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue && !dmem_ack) begin
                        state      <= ST_WAIT;
                        h_addr     <= Result_EX;
                        h_wdata    <= WrDat_EX;
                        h_wreg     <= WriteReg_EX;
                        h_we       <= MemWrite_EX;
                        h_regwrite <= RegWrite_EX;
                        h_memtoreg <= MemToReg_EX;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack || expire) state <= ST_IDLE;
                    else if (flush)         state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (dmem_ack || expire) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
